// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P responder: C0 read queue with latency expander, C1 write FSM, small line memory.
// Optional build macro ASE_RD_JITTER_EN adds LFSR-driven read latency jitter.
`timescale 1ns/1ps

package ccip_host_mem_responder_pkg;
    localparam int CCIP_DATA_WIDTH = 512;

    typedef enum logic [1:0] {VC_VA = 2'd0, VC_VL0 = 2'd1, VC_VH0 = 2'd2, VC_VH1 = 2'd3} vc_t;
    typedef enum logic [1:0] {CL_1 = 2'd0, CL_2 = 2'd1, CL_3 = 2'd2, CL_4 = 2'd3} cl_len_t;

    localparam logic [3:0] RSP_RD = 4'h0;
    localparam logic [3:0] RSP_WR = 4'h1;

    typedef struct packed {
        vc_t         vc;
        logic        sop;
        cl_len_t     len;
        logic [3:0]  reqtype;
        logic [15:0] mdata;
        logic [41:0] addr;
    } TxHdr_t;

    typedef struct packed {
        vc_t         vc_used;
        logic        hitmiss;
        logic        format;
        logic [1:0]  clnum;
        logic [3:0]  resptype;
        logic [15:0] mdata;
    } RxHdr_t;
endpackage

module ccip_host_mem_responder
    import ccip_host_mem_responder_pkg::*;
#(
    parameter int MEM_LINES_LOG2 = 10,
    parameter int RD_LATENCY     = 8,
    parameter int RDQ_DEPTH_LOG2 = 5,
    parameter int ALMFULL_MARGIN = 8
) (
    input  logic                       clk,
    input  logic                       SoftReset,
    input  TxHdr_t                     C0TxHdr,
    input  logic                       C0TxRdValid,
    input  TxHdr_t                     C1TxHdr,
    input  logic [CCIP_DATA_WIDTH-1:0] C1TxData,
    input  logic                       C1TxWrValid,
    output RxHdr_t                     C0RxHdr,
    output logic [CCIP_DATA_WIDTH-1:0] C0RxData,
    output logic                       C0RxRdValid,
    output RxHdr_t                     C1RxHdr,
    output logic                       C1RxWrValid,
    output logic                       C0TxAlmFull,
    output logic                       C1TxAlmFull,
    output logic [3:0]                 err_status
);
    localparam int RDQ_DEPTH = 2**RDQ_DEPTH_LOG2;
    localparam int ML        = MEM_LINES_LOG2;

    typedef logic [ML-1:0]           line_t;
    typedef logic [RDQ_DEPTH_LOG2:0] qcnt_t;
    typedef struct packed {
        vc_t         vc;
        cl_len_t     len;
        logic [15:0] mdata;
        line_t       line;
        logic [31:0] ready;
    } rdq_ent_t;
    typedef enum logic {W_IDLE, W_BURST} wstate_t;

    logic [CCIP_DATA_WIDTH-1:0] mem [2**ML];
    rdq_ent_t                   rdq [RDQ_DEPTH];

    logic        rst_q;
    logic [31:0] cycle;
    logic [3:0]  err_q;
    qcnt_t       wr_ptr, rd_ptr, occ;
    logic [1:0]  rd_beat;
    rdq_ent_t    head;
    logic        rd_bad, rd_full, rd_push, rd_fire, rd_last;
    logic [31:0] new_ready;

    wstate_t     w_state, w_state_nxt;
    logic [1:0]  w_beat, w_beat_nxt;
    cl_len_t     w_len, w_len_nxt;
    logic [15:0] w_mdata, w_mdata_nxt;
    line_t       w_base, w_base_nxt;
    logic        w_drop, w_drop_nxt;
    logic        mem_we, wr_rsp;
    line_t       mem_line;
    RxHdr_t      wr_rsp_hdr;
    logic [3:0]  werr;

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{C0TxHdr.sop, C0TxHdr.reqtype, C0TxHdr.addr[41:ML],
                               C1TxHdr.vc, C1TxHdr.reqtype, C1TxHdr.addr[41:ML]};

    // Read request queue: head stays resident until its last beat has been emitted.
    assign occ     = wr_ptr - rd_ptr;
    assign head    = rdq[rd_ptr[RDQ_DEPTH_LOG2-1:0]];
    assign rd_bad  = C0TxRdValid && (C0TxHdr.len == CL_3);
    assign rd_full = (occ == qcnt_t'(RDQ_DEPTH));
    assign rd_push = !SoftReset && C0TxRdValid && !rd_bad && !rd_full;
    assign rd_fire = !SoftReset && (occ != '0) && (cycle >= head.ready);
    assign rd_last = rd_fire && (rd_beat == head.len);

`ifdef ASE_RD_JITTER_EN
    logic [15:0] lfsr;
    logic [31:0] prev_ready, jit_ready;
    assign jit_ready = cycle + 32'(RD_LATENCY) + {29'd0, lfsr[2:0]};
    // Clamping to the previous ready time keeps responses in request order.
    assign new_ready = (jit_ready > prev_ready) ? jit_ready : prev_ready;

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            lfsr       <= 16'hACE1;
            prev_ready <= '0;
        end else if (rd_push) begin
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            prev_ready <= new_ready;
        end
    end
`else
    assign new_ready = cycle + 32'(RD_LATENCY);
`endif

    // NOTE: storage arrays carry no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (rd_push)
            rdq[wr_ptr[RDQ_DEPTH_LOG2-1:0]] <= '{vc: C0TxHdr.vc, len: C0TxHdr.len, mdata: C0TxHdr.mdata,
                                                  line: C0TxHdr.addr[ML-1:0], ready: new_ready};
        if (mem_we)
            mem[mem_line] <= C1TxData;
    end

    always_comb begin
        C0RxHdr     = '0;
        C0RxData    = '0;
        C0RxRdValid = rd_fire;
        if (rd_fire) begin
            C0RxHdr.vc_used  = (head.vc == VC_VA) ? VC_VL0 : head.vc;
            C0RxHdr.clnum    = rd_beat;
            C0RxHdr.resptype = RSP_RD;
            C0RxHdr.mdata    = head.mdata;
            C0RxData         = mem[head.line + line_t'(rd_beat)];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = w_state;
        w_beat_nxt  = w_beat;
        w_len_nxt   = w_len;
        w_mdata_nxt = w_mdata;
        w_base_nxt  = w_base;
        w_drop_nxt  = w_drop;
        mem_we      = 1'b0;
        mem_line    = w_base + line_t'(w_beat);
        wr_rsp      = 1'b0;
        wr_rsp_hdr  = '0;
        werr        = '0;
        if (C1TxWrValid && !SoftReset) begin
            if (C1TxHdr.sop) begin
                werr[3]     = (w_state == W_BURST);
                w_state_nxt = W_IDLE;
                w_drop_nxt  = 1'b0;
                if (C1TxHdr.len == CL_3) begin
                    werr[0]    = 1'b1;
                    w_drop_nxt = 1'b1;
                end else begin
                    w_len_nxt   = C1TxHdr.len;
                    w_mdata_nxt = C1TxHdr.mdata;
                    w_base_nxt  = C1TxHdr.addr[ML-1:0];
                    mem_we      = 1'b1;
                    mem_line    = C1TxHdr.addr[ML-1:0];
                    if (C1TxHdr.len == CL_1) begin
                        wr_rsp           = 1'b1;
                        wr_rsp_hdr.clnum = C1TxHdr.len;
                        wr_rsp_hdr.mdata = C1TxHdr.mdata;
                    end else begin
                        w_state_nxt = W_BURST;
                        w_beat_nxt  = 2'd1;
                    end
                end
            end else if (w_state == W_BURST) begin
                mem_we = 1'b1;
                if (w_beat == w_len) begin
                    wr_rsp           = 1'b1;
                    wr_rsp_hdr.clnum = w_len;
                    wr_rsp_hdr.mdata = w_mdata;
                    w_state_nxt      = W_IDLE;
                end else begin
                    w_beat_nxt = w_beat + 2'd1;
                end
            end else begin
                werr[2] = !w_drop;
            end
        end
        if (wr_rsp) begin
            wr_rsp_hdr.format   = 1'b1;
            wr_rsp_hdr.resptype = RSP_WR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            w_state <= W_IDLE;
            w_beat  <= '0;
            w_len   <= CL_1;
            w_mdata <= '0;
            w_base  <= '0;
            w_drop  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            w_beat  <= w_beat_nxt;
            w_len   <= w_len_nxt;
            w_mdata <= w_mdata_nxt;
            w_base  <= w_base_nxt;
            w_drop  <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= SoftReset;
        if (SoftReset) begin
            cycle       <= '0;
            err_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_beat     <= '0;
            C1RxWrValid <= 1'b0;
            C1RxHdr     <= '0;
        end else begin
            cycle       <= cycle + 32'd1;
            err_q       <= err_q | werr | {2'b00, C0TxRdValid && !rd_bad && rd_full, rd_bad};
            C1RxWrValid <= wr_rsp;
            C1RxHdr     <= wr_rsp_hdr;
            if (rd_push)
                wr_ptr <= wr_ptr + qcnt_t'(1);
            if (rd_fire) begin
                rd_beat <= rd_last ? 2'd0 : rd_beat + 2'd1;
                if (rd_last)
                    rd_ptr <= rd_ptr + qcnt_t'(1);
            end
        end
    end

    assign err_status  = err_q;
    assign C0TxAlmFull = rst_q || (occ >= qcnt_t'(RDQ_DEPTH - ALMFULL_MARGIN));
    assign C1TxAlmFull = rst_q;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Scoreboard bench for ccip_host_mem_responder: a cycle model of the read queue predicts
// beat timing, drops and C0TxAlmFull; write responses and error bits are predicted per test.
`timescale 1ns/1ps

module tb_ccip_host_mem_responder;
    import ccip_host_mem_responder_pkg::*;

    localparam int RD_LATENCY = 8;
    localparam int DEPTH      = 32;
    localparam int MARGIN     = 8;
    localparam int W          = CCIP_DATA_WIDTH;

    logic         clk = 1'b0;
    logic         SoftReset;
    TxHdr_t       C0TxHdr, C1TxHdr;
    logic         C0TxRdValid, C1TxWrValid;
    logic [W-1:0] C1TxData, C0RxData;
    RxHdr_t       C0RxHdr, C1RxHdr;
    logic         C0RxRdValid, C1RxWrValid, C0TxAlmFull, C1TxAlmFull;
    logic [3:0]   err_status;

    ccip_host_mem_responder #(
        .MEM_LINES_LOG2(10), .RD_LATENCY(RD_LATENCY), .RDQ_DEPTH_LOG2(5), .ALMFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .SoftReset(SoftReset),
        .C0TxHdr(C0TxHdr), .C0TxRdValid(C0TxRdValid),
        .C1TxHdr(C1TxHdr), .C1TxData(C1TxData), .C1TxWrValid(C1TxWrValid),
        .C0RxHdr(C0RxHdr), .C0RxData(C0RxData), .C0RxRdValid(C0RxRdValid),
        .C1RxHdr(C1RxHdr), .C1RxWrValid(C1RxWrValid),
        .C0TxAlmFull(C0TxAlmFull), .C1TxAlmFull(C1TxAlmFull), .err_status(err_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] mdata;
        logic [1:0]  clnum;
        logic [1:0]  vc;
        logic [W-1:0] data;
        bit          chk_data;
        int          req_cyc;
        int          exp_cyc;
    } rd_exp_t;
    typedef struct {
        logic [15:0] mdata;
        logic [1:0]  clnum;
        int          exp_cyc;
    } wr_exp_t;

    rd_exp_t      rd_sb[$];
    wr_exp_t      wr_sb[$];
    logic [W-1:0] mem_m[int];
    int           pend_last[$];
    int           last_end;
    logic [3:0]   exp_err;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int v);
        return {16{32'(v)}};
    endfunction

    always @(negedge clk) begin : monitor
        rd_exp_t e;
        wr_exp_t w;
        if (C0RxRdValid === 1'b1) begin
            check("rd_expected", rd_sb.size() != 0, 1'b1);
            if (rd_sb.size() != 0) begin
                e = rd_sb.pop_front();
                check("rd_mdata", C0RxHdr.mdata, e.mdata);
                check("rd_clnum", C0RxHdr.clnum, e.clnum);
                check("rd_vc_used", C0RxHdr.vc_used, e.vc);
                check("rd_resptype", C0RxHdr.resptype, RSP_RD);
`ifdef ASE_RD_JITTER_EN
                check("rd_latency_in_range",
                      (cyc - e.req_cyc - int'(e.clnum) >= RD_LATENCY) &&
                      (cyc - e.req_cyc - int'(e.clnum) <= RD_LATENCY + 7), 1'b1);
`else
                check("rd_cycle", cyc, e.exp_cyc);
`endif
                if (e.chk_data) check("rd_data", C0RxData, e.data);
            end
        end
        if (C1RxWrValid === 1'b1) begin
            check("wr_expected", wr_sb.size() != 0, 1'b1);
            if (wr_sb.size() != 0) begin
                w = wr_sb.pop_front();
                check("wr_mdata", C1RxHdr.mdata, w.mdata);
                check("wr_clnum", C1RxHdr.clnum, w.clnum);
                check("wr_format", C1RxHdr.format, 1'b1);
                check("wr_resptype", C1RxHdr.resptype, RSP_WR);
                check("wr_cycle", cyc, w.exp_cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            C0TxRdValid = 1'b0;
            C1TxWrValid = 1'b0;
        end
    endtask

    // Issues one read and predicts its fate from the queue model.
    task automatic rd_req(input logic [41:0] addr, input cl_len_t len, input logic [15:0] mdata, input vc_t vc);
        int      nb, occ, first, line;
        rd_exp_t e;
        tick();
        C1TxWrValid = 1'b0;
        C0TxHdr     = '{vc: vc, sop: 1'b1, len: len, reqtype: 4'h0, mdata: mdata, addr: addr};
        C0TxRdValid = 1'b1;
        while (pend_last.size() != 0 && pend_last[0] < cyc) void'(pend_last.pop_front());
        occ = pend_last.size();
`ifndef ASE_RD_JITTER_EN
        check("c0_almfull", C0TxAlmFull, occ >= DEPTH - MARGIN);
`endif
        if (len == CL_3) begin
            exp_err[0] = 1'b1;
        end else if (occ >= DEPTH) begin
            exp_err[1] = 1'b1;
        end else begin
            nb    = int'(len) + 1;
            first = cyc + RD_LATENCY;
            if (last_end + 1 > first) first = last_end + 1;
            last_end = first + nb - 1;
            pend_last.push_back(last_end);
            for (int k = 0; k < nb; k++) begin
                line       = (int'(addr[9:0]) + k) % 1024;
                e.mdata    = mdata;
                e.clnum    = 2'(k);
                e.vc       = (vc == VC_VA) ? VC_VL0 : vc;
                e.chk_data = mem_m.exists(line);
                e.data     = e.chk_data ? mem_m[line] : '0;
                e.req_cyc  = cyc;
                e.exp_cyc  = first + k;
                rd_sb.push_back(e);
            end
        end
    endtask

    task automatic wr_beat(input logic [41:0] addr, input cl_len_t len, input bit sop, input logic [15:0] mdata,
                           input logic [W-1:0] data, input int line, input bit rsp);
        tick();
        C0TxRdValid = 1'b0;
        C1TxHdr     = '{vc: VC_VA, sop: sop, len: len, reqtype: 4'h1, mdata: mdata, addr: addr};
        C1TxData    = data;
        C1TxWrValid = 1'b1;
        if (line >= 0) mem_m[line % 1024] = data;
        if (rsp) wr_sb.push_back('{mdata: mdata, clnum: 2'(len), exp_cyc: cyc + 1});
    endtask

    task automatic wr_burst(input logic [41:0] addr, input cl_len_t len, input logic [15:0] mdata, input int seed);
        int nb;
        nb = int'(len) + 1;
        for (int k = 0; k < nb; k++)
            wr_beat(addr, len, k == 0, mdata, pat(seed + k), int'(addr[9:0]) + k, k == nb - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while ((rd_sb.size() != 0 || wr_sb.size() != 0) && n < 500) begin
            idle(1);
            n++;
        end
        check("drain_done", rd_sb.size() + wr_sb.size(), 0);
        idle(4);
    endtask

    task automatic do_reset();
        tick();
        SoftReset   = 1'b1;
        C0TxRdValid = 1'b0;
        C1TxWrValid = 1'b0;
        tick();
        tick();
        SoftReset = 1'b0;
        pend_last.delete();
        rd_sb.delete();
        wr_sb.delete();
        last_end = -1;
        exp_err  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        last_end    = -1;
        exp_err     = '0;
        SoftReset   = 1'b1;
        C0TxRdValid = 1'b1;
        C1TxWrValid = 1'b1;
        C0TxHdr     = '{vc: VC_VA, sop: 1'b1, len: CL_1, reqtype: 4'h0, mdata: 16'h55, addr: 42'h0};
        C1TxHdr     = '{vc: VC_VA, sop: 1'b1, len: CL_1, reqtype: 4'h1, mdata: 16'h56, addr: 42'h0};
        C1TxData    = pat(7);

        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_c0_valid", C0RxRdValid, 1'b0);
            check("rst_c1_valid", C1RxWrValid, 1'b0);
            check("rst_err", err_status, 4'h0);
            check("rst_c0_almfull", C0TxAlmFull, 1'b1);
            check("rst_c1_almfull", C1TxAlmFull, 1'b1);
        end
        tick();
        SoftReset   = 1'b0;
        C0TxRdValid = 1'b0;
        C1TxWrValid = 1'b0;
        @(negedge clk);
        check("release_c0_almfull_hold", C0TxAlmFull, 1'b1);
        check("release_c1_almfull_hold", C1TxAlmFull, 1'b1);
        @(negedge clk);
        check("release_c0_almfull_drop", C0TxAlmFull, 1'b0);
        check("release_c1_almfull_drop", C1TxAlmFull, 1'b0);

        // 1CL write, then a 1CL read two cycles later
        wr_beat(42'h10, CL_1, 1'b1, 16'h3, {64{8'hA5}}, 16, 1'b1);
        idle(1);
        rd_req(42'h10, CL_1, 16'h11, VC_VA);
        drain();

        // 4CL write/read, followed back-to-back by 2CL and 1CL reads
        wr_burst(42'h20, CL_4, 16'h4, 100);
        idle(1);
        rd_req(42'h20, CL_4, 16'h21, VC_VA);
        rd_req(42'h22, CL_2, 16'h22, VC_VH1);
        rd_req(42'h10, CL_1, 16'h23, VC_VL0);
        drain();

        // Same-cycle write and read beat to one line: the read sees the old data
        wr_beat(42'h30, CL_1, 1'b1, 16'h30, pat(300), 48, 1'b1);
        drain();
        rd_req(42'h30, CL_1, 16'h31, VC_VL0);
        idle(7);
        wr_beat(42'h30, CL_1, 1'b1, 16'h32, pat(301), 48, 1'b1);
        drain();
        rd_req(42'h30, CL_1, 16'h33, VC_VH0);
        drain();
        check("err_clean", err_status, 4'h0);

`ifndef ASE_RD_JITTER_EN
        // 4CL reads drain at a quarter of the issue rate, so the queue genuinely fills
        for (int i = 0; i < 48; i++)
            rd_req(42'h100 + 42'(4 * i), CL_4, 16'h200 + 16'(i), VC_VH0);
        drain();
        check("flood_overflow_seen", exp_err[1], 1'b1);
        check("err_flood", err_status, exp_err);
`else
        for (int i = 0; i < 16; i++)
            rd_req(42'h40 + 42'(i), CL_1, 16'h300 + 16'(i), VC_VL0);
        drain();
`endif

        // 3CL read: dropped, memory survives reset
        do_reset();
        rd_req(42'h10, CL_3, 16'h41, VC_VA);
        idle(2);
        check("err_3cl_read", err_status, exp_err);
        rd_req(42'h10, CL_1, 16'h42, VC_VA);
        drain();

        // Orphan non-sop beat
        do_reset();
        wr_beat(42'h50, CL_1, 1'b0, 16'h50, pat(500), -1, 1'b0);
        exp_err[2] = 1'b1;
        idle(2);
        check("err_orphan", err_status, exp_err);
        drain();

        // sop inside a 2CL burst: only the second burst responds
        do_reset();
        wr_beat(42'h60, CL_2, 1'b1, 16'h61, pat(600), 96, 1'b0);
        wr_beat(42'h68, CL_2, 1'b1, 16'h62, pat(700), 104, 1'b0);
        wr_beat(42'h68, CL_2, 1'b0, 16'h62, pat(701), 105, 1'b1);
        exp_err[3] = 1'b1;
        idle(2);
        check("err_sop_in_burst", err_status, exp_err);
        drain();
        rd_req(42'h68, CL_2, 16'h63, VC_VH1);
        drain();

        // 3CL write burst is ignored entirely, no orphan flag on its trailing beats
        do_reset();
        wr_beat(42'h70, CL_1, 1'b1, 16'h70, pat(800), 112, 1'b1);
        wr_beat(42'h70, CL_3, 1'b1, 16'h71, pat(900), -1, 1'b0);
        wr_beat(42'h70, CL_3, 1'b0, 16'h71, pat(901), -1, 1'b0);
        wr_beat(42'h70, CL_3, 1'b0, 16'h71, pat(902), -1, 1'b0);
        exp_err[0] = 1'b1;
        idle(2);
        check("err_3cl_write", err_status, exp_err);
        drain();
        rd_req(42'h70, CL_1, 16'h72, VC_VL0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
